// File: rtl/denise_colortable_ram.sv
// Denise colour lookup RAM: 256 x 32-bit simple dual-port block RAM.
// Port A takes byte-masked colour-register writes, so LOCT writes can touch
// only the low 12-bit half. Port B is the registered pixel-select read port.
// The array has no reset; its power-up contents come from the FPGA
// configuration. rst clears only the read register, so the array still maps
// onto block RAM.

module denise_colortable_ram #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int NB_BYTES = DATA_W / 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [NB_BYTES-1:0] wea,
  input  logic [ADDR_W-1:0]   addra,
  input  logic [DATA_W-1:0]   dina,
  input  logic                enb,
  input  logic [ADDR_W-1:0]   addrb,
  output logic [DATA_W-1:0]   doutb
);

  localparam int Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] memQ [0:Depth-1];
  logic [DATA_W-1:0] doutbQ;

  // Port A: each enabled byte lane updates its byte; other lanes keep their contents
  always_ff @(posedge clk) begin
    if (ena) begin
      for (int i = 0; i < NB_BYTES; i++) begin
        if (wea[i]) begin
          memQ[addra][8*i +: 8] <= dina[8*i +: 8];
        end
      end
    end
  end

  // Port B: registered read-first output, cleared asynchronously by rst and held when enb is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      doutbQ <= '0;
    end else if (enb) begin
      doutbQ <= memQ[addrb];
    end
  end

  assign doutb = doutbQ;

endmodule

// File: tb/tb_denise_colortable_ram.sv
// Scoreboard bench for denise_colortable_ram: a reference memory predicts
// each read when it is issued and the prediction is compared one clock later.

module tb_denise_colortable_ram;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [3:0]  wea;
  logic [7:0]  addra;
  logic [31:0] dina;
  logic        enb;
  logic [7:0]  addrb;
  logic [31:0] doutb;

  logic [31:0] refMem [0:255];
  logic [31:0] expQueue [$];
  logic [31:0] lastExp;
  int          checkCount;
  int          errorCount;

  denise_colortable_ram #(
    .ADDR_W   (8),
    .DATA_W   (32),
    .NB_BYTES (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .enb   (enb),
    .addrb (addrb),
    .doutb (doutb)
  );

  // 100 MHz free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it when the observed value differs
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drives one clock of port A/B activity. A read's prediction is taken from
  // the reference memory before this cycle's write lands (read-first), and is
  // checked just after the edge that loads doutb.
  task automatic applyStimulus(input string tag, input logic wEn,
                               input logic [3:0] wBytes, input logic [7:0] wAddr,
                               input logic [31:0] wData, input logic rEn,
                               input logic [7:0] rAddr);
    logic pushed;
    pushed = 1'b0;
    ena   = wEn;
    wea   = wBytes;
    addra = wAddr;
    dina  = wData;
    enb   = rEn;
    addrb = rAddr;
    if (rEn && !rst) begin
      expQueue.push_back(refMem[rAddr]);
      pushed = 1'b1;
    end
    if (wEn) begin
      for (int i = 0; i < 4; i++) begin
        if (wBytes[i]) refMem[wAddr][8*i +: 8] = wData[8*i +: 8];
      end
    end
    @(posedge clk);
    #1;
    if (pushed) begin
      lastExp = expQueue.pop_front();
      checkOutput(tag, doutb, lastExp);
    end
    ena = 1'b0;
    enb = 1'b0;
    wea = 4'h0;
  endtask

  initial begin
    logic [7:0] a;
    checkCount = 0;
    errorCount = 0;
    lastExp    = '0;
    for (int i = 0; i < 256; i++) refMem[i] = '0;
    rst   = 1'b1;
    ena   = 1'b0;
    wea   = 4'h0;
    addra = 8'h00;
    dina  = '0;
    enb   = 1'b0;
    addrb = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", doutb, 32'h0);
    rst = 1'b0;

    // Full-word write then read
    applyStimulus("full_write", 1'b1, 4'hF, 8'h05, 32'h0ABC_0123, 1'b0, 8'h00);
    applyStimulus("full_read",  1'b0, 4'h0, 8'h00, 32'h0,         1'b1, 8'h05);
    checkOutput("full_value", lastExp, 32'h0ABC_0123);

    // Low-half byte-masked merge
    applyStimulus("loct_write", 1'b1, 4'b0011, 8'h05, 32'h0FFF_0456, 1'b0, 8'h00);
    applyStimulus("loct_read",  1'b0, 4'h0,    8'h00, 32'h0,         1'b1, 8'h05);
    checkOutput("loct_value", doutb, 32'h0ABC_0456);

    // Read-first collision on the same edge
    applyStimulus("coll_init",  1'b1, 4'hF, 8'h10, 32'h1111_1111, 1'b0, 8'h00);
    applyStimulus("coll_old",   1'b1, 4'hF, 8'h10, 32'h2222_2222, 1'b1, 8'h10);
    checkOutput("coll_old_value", doutb, 32'h1111_1111);
    applyStimulus("coll_new",   1'b0, 4'h0, 8'h00, 32'h0,         1'b1, 8'h10);
    checkOutput("coll_new_value", doutb, 32'h2222_2222);

    // ena low blocks the write even with all byte enables set
    applyStimulus("ena_clear",  1'b1, 4'hF, 8'h20, 32'h0,         1'b0, 8'h00);
    applyStimulus("ena_off",    1'b0, 4'hF, 8'h20, 32'hDEAD_BEEF, 1'b0, 8'h00);
    applyStimulus("ena_read",   1'b0, 4'h0, 8'h00, 32'h0,         1'b1, 8'h20);
    checkOutput("ena_value", doutb, 32'h0);

    // enb low holds doutb while addrb moves
    applyStimulus("hold_load",  1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h05);
    applyStimulus("hold_1",     1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h10);
    checkOutput("hold_1", doutb, 32'h0ABC_0456);
    applyStimulus("hold_2",     1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h20);
    checkOutput("hold_2", doutb, 32'h0ABC_0456);

    // Asynchronous reset mid-cycle, with a write honoured while in reset
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", doutb, 32'h0);
    applyStimulus("reset_write", 1'b1, 4'hF, 8'h30, 32'h3333_3333, 1'b1, 8'h05);
    checkOutput("reset_suppressed", doutb, 32'h0);
    rst = 1'b0;
    applyStimulus("post_reset_05", 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h05);
    checkOutput("survive_05", doutb, 32'h0ABC_0456);
    applyStimulus("post_reset_30", 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h30);
    checkOutput("survive_30", doutb, 32'h3333_3333);

    // Address sweep: distinct pattern per word, then read every word back
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      applyStimulus("sweep_write", 1'b1, 4'hF, a, {8'h00, a, 8'h00, ~a}, 1'b0, 8'h00);
    end
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      applyStimulus("sweep_read", 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, a);
    end
    checkOutput("sweep_last", doutb, 32'h00FF_0000);

    checkOutput("queue_drained", 32'(expQueue.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/denise_colortable_ram.md
Name: denise_colortable_ram

Overview:
- Simple dual-port colour lookup RAM for the Denise HAM/colour generator: 256 entries × 32 bits, with per-byte write enables.
- Port A is write-only and is fed by colour-register writes (bank:register address). Port B is read-only and is addressed by the playfield pixel select.
- Each 32-bit word holds two 12-bit colour halves (high nibbles in bits 27:16, low nibbles in bits 11:0). The byte enables let LOCT writes update only the low half.

Parameters:
- ADDR_W, 8, address width; depth = 2^ADDR_W.
- DATA_W, 32, word width; must be a multiple of 8.
- NB_BYTES, DATA_W/8 (4), number of byte-lane write enables.

Ports:
- clk  in  1  single clock shared by both ports (28 MHz domain).
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  port A enable; writes only occur when high.
- wea  in  NB_BYTES  byte write enables; bit i covers dina[8i+7:8i].
- addra  in  ADDR_W  write address.
- dina  in  DATA_W  write data.
- enb  in  1  port B enable; read register updates only when high.
- addrb  in  ADDR_W  read address.
- doutb  out  DATA_W  registered read data.

Behaviour:
- Memory array: 2^ADDR_W words. All words power up (bitstream init) to 0. rst does NOT clear the array.
- Write: at posedge clk, when ena=1, for each i with wea[i]=1, mem[addra] byte i <= dina byte i. Bytes with wea[i]=0 keep their value. ena=0 or wea=0 means no write.
- Read: at posedge clk, when enb=1, doutb <= mem[addrb]. Latency is exactly 1 clock from addrb to doutb. When enb=0, doutb holds its value.
- Read-during-write to the same address on the same edge is read-first: doutb gets the pre-write contents. The new data is visible from the next read edge onward.
- Writes to one address never disturb other addresses. Addresses are full-width, with no wrap or aliasing beyond 2^ADDR_W.
- Reset: while rst=1, doutb = 0, asynchronously and immediately. Reads are suppressed during reset; writes to the array are still honoured. After rst deasserts, the first enabled read edge loads doutb normally.
- No combinational path from any input to doutb.
- Must infer block RAM on the target FPGA. The async reset applies only to the output register, never to the array.

Test Plan:
- Full-word write then read: write addra=8'h05, wea=4'hF, dina=32'h0ABC_0123. Next cycle set addrb=8'h05, enb=1 → doutb=32'h0ABC_0123 one clock after the read edge.
- Byte-enable (LOCT) merge: mem[8'h05]=32'h0ABC_0123; write wea=4'b0011, dina=32'h0FFF_0456 → read gives 32'h0ABC_0456.
- Read-first collision: mem[8'h10]=32'h1111_1111; on one edge write 32'h2222_2222 to 8'h10 while addrb=8'h10 → doutb=32'h1111_1111. Next edge → 32'h2222_2222.
- Enables: ena=0 with wea=4'hF at 8'h20 leaves mem[8'h20]=0. With enb=0 and addrb changing, doutb holds its previous value.
- Async reset: doutb=32'h0ABC_0456, assert rst mid-cycle → doutb=0 before the next edge. Deassert rst, read 8'h05 → 32'h0ABC_0456, proving contents survived reset.
- Address sweep: write mem[a]={8'h0,a,8'h0,~a} for a=0..255, then read all 256 back. Every word matches, including boundaries 0 and 255, with no aliasing.
